gate_bist: RTL



---
 rtl/gate_bist.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gate_bist.sv
// Exhaustive self-test sequencer for small combinational gates: walks every
// input vector, waits a settle time, and checks the DUT against a reference.
module gate_bist #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func_i,
  output logic [N_IN-1:0] dut_in_o,
  input  logic            dut_out_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN-1:0] fail_vec_o,
  output logic            fail_got_o,
  output logic            fail_exp_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    F_AND  = 3'd0,
    F_OR   = 3'd1,
    F_XOR  = 3'd2,
    F_NAND = 3'd3,
    F_NOR  = 3'd4,
    F_XNOR = 3'd5,
    F_BUF  = 3'd6,
    F_INV  = 3'd7
  } func_e;

  state_e          state_q, state_d;
  func_e           func_q, func_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic            fail_got_q, fail_got_d;
  logic            fail_exp_q, fail_exp_d;

  logic            exp_c;
  logic            mismatch_c;

  // Reference value for the vector currently on the DUT.
  always_comb begin
    exp_c = 1'b0;
    unique case (func_q)
      F_AND:  exp_c = &dut_in_q;
      F_OR:   exp_c = |dut_in_q;
      F_XOR:  exp_c = ^dut_in_q;
      F_NAND: exp_c = ~(&dut_in_q);
      F_NOR:  exp_c = ~(|dut_in_q);
      F_XNOR: exp_c = ~(^dut_in_q);
      F_BUF:  exp_c = dut_in_q[0];
      F_INV:  exp_c = ~dut_in_q[0];
      default: exp_c = 1'b0;
    endcase
  end

  // Case inequality so an X/Z response is flagged as a mismatch in simulation.
  assign mismatch_c = (dut_out_i !== exp_c);

  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    cnt_d      = cnt_q;
    dut_in_d   = dut_in_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    fail_got_d = fail_got_q;
    fail_exp_d = fail_exp_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_APPLY;
          func_d     = func_e'(func_i);
          cnt_d      = SETTLE_CNT;
          dut_in_d   = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          fail_vec_d = '0;
          fail_got_d = 1'b0;
          fail_exp_d = 1'b0;
        end
      end

      S_APPLY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (mismatch_c) begin
          state_d    = S_DONE;
          fail_vec_d = dut_in_q;
          fail_got_d = dut_out_i;
          fail_exp_d = exp_c;
          pass_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (&dut_in_q) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          dut_in_d = dut_in_q + N_IN'(1);
          cnt_d    = SETTLE_CNT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      func_q     <= F_AND;
      cnt_q      <= '0;
      dut_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      fail_got_q <= 1'b0;
      fail_exp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      cnt_q      <= cnt_d;
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      fail_got_q <= fail_got_d;
      fail_exp_q <= fail_exp_d;
    end
  end

  assign dut_in_o   = dut_in_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign fail_vec_o = fail_vec_q;
  assign fail_got_o = fail_got_q;
  assign fail_exp_o = fail_exp_q;

endmodule
